// File: rtl/cpu_hazard.sv
// Falcon decode-stage hazard and bypass control. Tracks the destinations in p3/p4,
// picks the operand bypass sources and holds the front end for one cycle on load-use.
module cpu_hazard (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_valid,
  input  logic [4:0]  p2_reg_a,
  input  logic [4:0]  p2_reg_b,
  input  logic        p2_use_a,
  input  logic        p2_use_b,
  input  logic [4:0]  p2_reg_d,
  input  logic        p2_write_en,
  input  logic        p2_is_load,
  output logic        p2_bypass_3_a,
  output logic        p2_bypass_3_b,
  output logic        p2_bypass_4_a,
  output logic        p2_bypass_4_b,
  output logic        p2_hazard,
  output logic [4:0]  p4_reg_d,
  output logic        p4_write_en,
  output logic [31:0] hazard_count
);

  logic [4:0]  p3_reg_d_q, p3_reg_d_d;
  logic        p3_write_en_q, p3_write_en_d;
  logic        p3_is_load_q, p3_is_load_d;
  logic [4:0]  p4_reg_d_q, p4_reg_d_d;
  logic        p4_write_en_q, p4_write_en_d;
  logic [31:0] hazard_count_q, hazard_count_d;

  logic m3_a, m3_b, m4_a, m4_b;

  always_comb begin
    m3_a = p2_use_a & p3_write_en_q & (p3_reg_d_q == p2_reg_a);
    m3_b = p2_use_b & p3_write_en_q & (p3_reg_d_q == p2_reg_b);
    m4_a = p2_use_a & p4_write_en_q & (p4_reg_d_q == p2_reg_a);
    m4_b = p2_use_b & p4_write_en_q & (p4_reg_d_q == p2_reg_b);

    p2_hazard     = p2_valid & p3_is_load_q & (m3_a | m3_b);
    p2_bypass_3_a = m3_a & ~p3_is_load_q;
    p2_bypass_3_b = m3_b & ~p3_is_load_q;
    // The operand mux favours p4, so a younger p3 match must mask it here.
    p2_bypass_4_a = m4_a & ~m3_a;
    p2_bypass_4_b = m4_b & ~m3_b;
  end

  always_comb begin
    p3_reg_d_d     = p3_reg_d_q;
    p3_write_en_d  = p3_write_en_q;
    p3_is_load_d   = p3_is_load_q;
    p4_reg_d_d     = p4_reg_d_q;
    p4_write_en_d  = p4_write_en_q;
    hazard_count_d = hazard_count_q;
    if (!stall) begin
      p4_reg_d_d    = p3_reg_d_q;
      p4_write_en_d = p3_write_en_q;
      if (p2_hazard) begin
        p3_reg_d_d     = 5'd0;
        p3_write_en_d  = 1'b0;
        p3_is_load_d   = 1'b0;
        hazard_count_d = hazard_count_q + 32'd1;
      end else begin
        // r0 is hardwired, so it is never tracked as a bypass source.
        p3_reg_d_d    = p2_reg_d;
        p3_write_en_d = p2_valid & p2_write_en & (p2_reg_d != 5'd0);
        p3_is_load_d  = p2_valid & p2_is_load;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p3_reg_d_q     <= 5'd0;
      p3_write_en_q  <= 1'b0;
      p3_is_load_q   <= 1'b0;
      p4_reg_d_q     <= 5'd0;
      p4_write_en_q  <= 1'b0;
      hazard_count_q <= 32'd0;
    end else begin
      p3_reg_d_q     <= p3_reg_d_d;
      p3_write_en_q  <= p3_write_en_d;
      p3_is_load_q   <= p3_is_load_d;
      p4_reg_d_q     <= p4_reg_d_d;
      p4_write_en_q  <= p4_write_en_d;
      hazard_count_q <= hazard_count_d;
    end
  end

  assign p4_reg_d     = p4_reg_d_q;
  assign p4_write_en  = p4_write_en_q;
  assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_cpu_hazard.sv
// Directed, table-driven bench for cpu_hazard: one vector per cycle, plus an
// asynchronous mid-cycle reset sequence at the end.
module tb_cpu_hazard;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        p2_valid;
  logic [4:0]  p2_reg_a;
  logic [4:0]  p2_reg_b;
  logic        p2_use_a;
  logic        p2_use_b;
  logic [4:0]  p2_reg_d;
  logic        p2_write_en;
  logic        p2_is_load;
  logic        p2_bypass_3_a;
  logic        p2_bypass_3_b;
  logic        p2_bypass_4_a;
  logic        p2_bypass_4_b;
  logic        p2_hazard;
  logic [4:0]  p4_reg_d;
  logic        p4_write_en;
  logic [31:0] hazard_count;

  cpu_hazard dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .p2_valid      (p2_valid),
    .p2_reg_a      (p2_reg_a),
    .p2_reg_b      (p2_reg_b),
    .p2_use_a      (p2_use_a),
    .p2_use_b      (p2_use_b),
    .p2_reg_d      (p2_reg_d),
    .p2_write_en   (p2_write_en),
    .p2_is_load    (p2_is_load),
    .p2_bypass_3_a (p2_bypass_3_a),
    .p2_bypass_3_b (p2_bypass_3_b),
    .p2_bypass_4_a (p2_bypass_4_a),
    .p2_bypass_4_b (p2_bypass_4_b),
    .p2_hazard     (p2_hazard),
    .p4_reg_d      (p4_reg_d),
    .p4_write_en   (p4_write_en),
    .hazard_count  (hazard_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags packs the expected {bypass_3_a, bypass_3_b, bypass_4_a, bypass_4_b, hazard}.
  typedef struct {
    int stall, valid, a, ua, b, ub, d, we, ld;
    int flags, p4d, p4we, cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(int stall, int valid, int a, int ua, int b, int ub,
                              int d, int we, int ld, int flags, int p4d, int p4we,
                              int cnt);
    vec_t v;
    v.stall = stall; v.valid = valid; v.a = a; v.ua = ua; v.b = b; v.ub = ub;
    v.d = d; v.we = we; v.ld = ld; v.flags = flags; v.p4d = p4d; v.p4we = p4we;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    stall       = v.stall[0];
    p2_valid    = v.valid[0];
    p2_reg_a    = v.a[4:0];
    p2_use_a    = v.ua[0];
    p2_reg_b    = v.b[4:0];
    p2_use_b    = v.ub[0];
    p2_reg_d    = v.d[4:0];
    p2_write_en = v.we[0];
    p2_is_load  = v.ld[0];
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_output(input string tag, input int flags, input int p4d,
                              input int p4we, input int cnt);
    logic [4:0] fl;
    fl = {p2_bypass_3_a, p2_bypass_3_b, p2_bypass_4_a, p2_bypass_4_b, p2_hazard};
    check({tag, " flags"}, int'(fl), flags);
    check({tag, " p4_reg_d"}, int'(p4_reg_d), p4d);
    check({tag, " p4_write_en"}, int'(p4_write_en), p4we);
    check({tag, " hazard_count"}, int'(hazard_count), cnt);
  endtask

  initial begin
    // ALU chain, gap-of-one, double writer, load-use, r0/literal, stalled hazard.
    vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 'b00000,  0,0,0)); // v0 reset state
    vecs.push_back(mk(0,1, 1,1, 2,1,  3,1,0, 'b00000,  0,0,0)); // add r3
    vecs.push_back(mk(0,1, 3,1, 4,1,  5,1,0, 'b10000,  0,0,0)); // add r5,r3,r4
    vecs.push_back(mk(0,1, 7,1, 3,1,  6,1,0, 'b00010,  3,1,0)); // sub r6,r7,r3
    vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 'b00000,  5,1,0));
    vecs.push_back(mk(0,1, 1,1, 2,1,  3,1,0, 'b00000,  6,1,0)); // add r3
    vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 'b00000,  0,0,0)); // nop gap
    vecs.push_back(mk(0,1, 7,1, 3,1,  6,1,0, 'b00010,  3,1,0)); // sub r6,r7,r3
    vecs.push_back(mk(0,1, 1,1, 2,1,  3,1,0, 'b00000,  0,0,0)); // add r3
    vecs.push_back(mk(0,1, 1,1, 2,1,  3,1,0, 'b00000,  6,1,0)); // add r3
    vecs.push_back(mk(0,1, 3,1, 4,1,  9,1,0, 'b10000,  3,1,0)); // add r9,r3,r4
    vecs.push_back(mk(0,1, 1,1, 0,0,  2,1,1, 'b00000,  3,1,0)); // ld r2
    vecs.push_back(mk(0,1, 2,1, 2,1,  8,1,0, 'b00001,  9,1,0)); // add r8,r2,r2 hazard
    vecs.push_back(mk(0,1, 2,1, 2,1,  8,1,0, 'b00110,  2,1,1)); // held, bypass from p4
    vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 'b00000,  0,0,1)); // bubble in p4
    vecs.push_back(mk(0,1, 1,1, 2,1,  0,1,0, 'b00000,  8,1,1)); // add r0
    vecs.push_back(mk(0,1, 0,1, 0,0, 10,1,0, 'b00000,  0,0,1)); // read r0, literal B
    vecs.push_back(mk(0,1, 1,1, 2,1, 12,1,0, 'b00000,  0,0,1)); // add r12
    vecs.push_back(mk(0,1, 1,1, 0,0,  4,1,1, 'b00000, 10,1,1)); // ld r4
    vecs.push_back(mk(1,1, 4,1, 5,1, 11,1,0, 'b00001, 12,1,1)); // stalled hazard x3
    vecs.push_back(mk(1,1, 4,1, 5,1, 11,1,0, 'b00001, 12,1,1));
    vecs.push_back(mk(1,1, 4,1, 5,1, 11,1,0, 'b00001, 12,1,1));
    vecs.push_back(mk(0,1, 4,1, 5,1, 11,1,0, 'b00001, 12,1,1)); // releasing edge
    vecs.push_back(mk(0,1, 4,1, 5,1, 11,1,0, 'b00100,  4,1,2));
    vecs.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 'b00000,  0,0,2));

    reset = 1'b1;
    apply_stimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d", i), vecs[i].flags, vecs[i].p4d,
                   vecs[i].p4we, vecs[i].cnt);
      @(posedge clock);
      #1;
    end

    // Reader of r11 sees p4 bypass; a mid-cycle reset must clear everything at once.
    apply_stimulus(mk(0,1, 11,1, 0,0, 13,1,0, 0,0,0,0));
    #1;
    check_output("pre_reset", 'b00100, 11, 1, 2);
    #1 reset = 1'b1;
    #1;
    check_output("async_reset", 'b00000, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check_output("post_reset", 'b00000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
